// File: rtl/xm23_clock_ctrl.sv
// XM23 clock-enable generator: RUN divides clock_in by a loadable ratio, STEP issues one
// tick per debounced button press, HALT issues nothing. Ticks drive cpu_ce, clock, led, tick_count.
module xm23_clock_ctrl #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int DEB_CYCLES  = 500_000,
    parameter int TCNT_W      = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              halt_req,
    input  logic [CNT_W-1:0]  div_value,
    input  logic              div_load,
    input  logic              step_btn,
    output logic              cpu_ce,
    output logic              clock,
    output logic              led,
    output logic [TCNT_W-1:0] tick_count
);
    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP_IDLE, S_STEP_WAIT_REL} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [1:0]        sync_q;
    logic              deb_q;
    logic [DW-1:0]     deb_cnt_q;
    logic              ce_q, clk_q, led_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic              tick;
    logic              eff_run, eff_step, in_step;

    assign eff_run  = !halt_req && (mode == 2'b01);
    assign eff_step = !halt_req && (mode == 2'b10);
    assign in_step  = (state_q == S_STEP_IDLE) || (state_q == S_STEP_WAIT_REL);

    always_comb begin
        state_d = S_HALT;
        cnt_d   = '0;
        div_d   = div_q;
        tick    = 1'b0;
        if (eff_run)
            state_d = S_RUN;
        else if (eff_step)
            state_d = in_step ? state_q : (deb_q ? S_STEP_WAIT_REL : S_STEP_IDLE);

        // Ticks only fire when the state is stable across the edge, so mode
        // changes and halt_req always swallow a coincident tick.
        if (state_q == S_RUN && state_d == S_RUN && !div_load) begin
            if (cnt_q == div_q - 1'b1)
                tick = 1'b1;
            else
                cnt_d = cnt_q + 1'b1;
        end
        if (state_q == S_STEP_IDLE && state_d == S_STEP_IDLE && deb_q) begin
            tick    = 1'b1;
            state_d = S_STEP_WAIT_REL;
        end
        if (state_q == S_STEP_WAIT_REL && state_d == S_STEP_WAIT_REL && !deb_q)
            state_d = S_STEP_IDLE;

        if (div_load)
            div_d = (div_value == '0) ? CNT_W'(1) : div_value;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= S_HALT;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            ce_q    <= 1'b0;
            clk_q   <= 1'b0;
            led_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ce_q    <= tick;
            clk_q   <= clk_q ^ tick;
            led_q   <= led_q ^ tick;
            tcnt_q  <= tcnt_q + TCNT_W'(tick);
        end
    end

    // Debouncer runs in every mode so leaving HALT never sees a stale edge.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], step_btn};
            if (sync_q[1] == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_q     <= sync_q[1];
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign cpu_ce     = ce_q;
    assign clock      = clk_q;
    assign led        = led_q;
    assign tick_count = tcnt_q;
endmodule
